// File: rtl/cpu_controller.sv
// cpu_controller: instruction register, decoder and FSM for a simple datapath.
// Optional sticky undefined-instruction trap: define CPU_CTRL_ILLEGAL_TRAP_EN.
`default_nettype none

module cpu_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic        write,
    output logic [1:0]  vsel,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GET_A  = 3'd2,
        S_GET_B  = 3'd3,
        S_ALU    = 3'd4,
        S_WR_REG = 3'd5,
        S_WR_IMM = 3'd6
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] ir;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [2:0] rm;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign rm     = ir[2:0];

    logic is_mov_imm, is_mov_reg, is_mvn, is_alu3, is_cmp, is_undef;

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_mvn     = (opcode == 3'b101) && (op == 2'b11);
    assign is_alu3    = (opcode == 3'b101) && (op != 2'b11);
    assign is_cmp     = (opcode == 3'b101) && (op == 2'b01);
    assign is_undef   = !(is_mov_imm || is_mov_reg || is_mvn || is_alu3);

    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};
    assign shift  = ir[4:3];
    assign ALUop  = (opcode == 3'b101) ? op : 2'b00;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_WAIT;
            ir    <= 16'h0000;
        end else begin
            state <= next_state;
            if (load) begin
                ir <= in;
            end
        end
    end

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_q <= 1'b0;
        end else if ((state == S_DECODE) && is_undef) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        next_state = state;
        w          = 1'b0;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        write      = 1'b0;
        vsel       = 2'b00;
        readnum    = 3'd0;
        writenum   = 3'd0;

        case (state)
            S_WAIT: begin
                w = 1'b1;
                // A trapped controller parks here until reset.
                if (s && !illegal) begin
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_mov_imm) begin
                    next_state = S_WR_IMM;
                end else if (is_mov_reg || is_mvn) begin
                    next_state = S_GET_B;
                end else if (is_alu3) begin
                    next_state = S_GET_A;
                end else begin
                    next_state = S_WAIT;
                end
            end
            S_GET_A: begin
                readnum    = rn;
                loada      = 1'b1;
                next_state = S_GET_B;
            end
            S_GET_B: begin
                readnum    = rm;
                loadb      = 1'b1;
                next_state = S_ALU;
            end
            S_ALU: begin
                loadc      = !is_cmp;
                loads      = is_cmp;
                asel       = is_mov_reg || is_mvn;
                next_state = is_cmp ? S_WAIT : S_WR_REG;
            end
            S_WR_REG: begin
                writenum   = rd;
                vsel       = 2'b00;
                write      = 1'b1;
                next_state = S_WAIT;
            end
            S_WR_IMM: begin
                writenum   = rn;
                vsel       = 2'b10;
                write      = 1'b1;
                next_state = S_WAIT;
            end
            default: begin
                next_state = S_WAIT;
            end
        endcase
    end

endmodule

`default_nettype wire
